// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply / divide unit for the execute stage.
//
// Multiply is shift-add, LSB first; divide is restoring. Each takes WIDTH
// iterations in CALC. A divide by zero skips CALC and completes right away.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        single-cycle request, only taken in IDLE or DONE
//   op           0 = multiply, 1 = divide
//   SrcA         multiplicand / dividend
//   SrcB         multiplier / divisor
//   result_lo    product low half / quotient
//   result_hi    product high half / remainder
//   busy         operation in flight (pipeline stall request)
//   done         one-cycle completion pulse; results valid from this cycle
//   div_by_zero  last divide had SrcB == 0; cleared on the next accepted start
//   Zero         multiply: product == 0; divide: quotient == 0
//   dbg_state    current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshake: a request is taken on any rising edge where start=1 and the
// unit is not busy (IDLE or DONE). busy is the only back-pressure, and done
// pulses for exactly one cycle per completed operation.
module muldiv_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             Zero,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic               op_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand (mul) or divisor (div)
  logic [2*WIDTH-1:0] acc_q;    // {hi, multiplier/product} or {rem, dividend/quotient}
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;

  assign dbg_state = state_q;

  // One iteration of the selected algorithm.
  always_comb begin
    mul_sum   = '0;
    div_shift = '0;
    div_diff  = '0;
    div_ge    = 1'b0;
    acc_d     = acc_q;
    // Multiply: the carry out of the upper-half add becomes the new MSB
    // after the right shift, so no product bit is lost.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    // Divide: {rem, dividend} << 1 exposes a WIDTH+1 bit partial remainder.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q) begin
      // The partial remainder stays below 2*divisor, so the kept value fits WIDTH bits.
      acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
               acc_q[WIDTH-2:0], div_ge};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      Zero        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_q        <= op;
            cnt_q       <= '0;
            div_by_zero <= 1'b0;
            if (op && (SrcB == '0)) begin
              // Divide by zero finishes on the accepting edge.
              state_q     <= S_DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              opnd_q      <= SrcB;
              acc_q       <= {{WIDTH{1'b0}}, SrcA};
              result_lo   <= '0;
              result_hi   <= SrcA;
              div_by_zero <= 1'b1;
              Zero        <= 1'b1;
            end else begin
              state_q <= S_CALC;
              busy    <= 1'b1;
              opnd_q  <= op ? SrcB : SrcA;
              acc_q   <= {{WIDTH{1'b0}}, (op ? SrcA : SrcB)};
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // Results are loaded only from the final iteration, so partial
            // values never reach the output ports.
            state_q   <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result_lo <= acc_d[WIDTH-1:0];
            result_hi <= acc_d[2*WIDTH-1:WIDTH];
            Zero      <= op_q ? (acc_d[WIDTH-1:0] == '0) : (acc_d == '0);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
